// File: rtl/prince_mask_pkg.sv
// Shared types, S-box tables and randomness layout for the masked PRINCE S-box pipeline.
// PRINCE_SBOX_REMASK_OUT_EN adds an output refresh register (latency 5, 51 random bits).
package prince_mask_pkg;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        nibble_t s3;
        nibble_t s2;
        nibble_t s1;
    } shares3_t;

    localparam nibble_t SBOX [16] = '{
        4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
    };

    localparam nibble_t SBOX_INV [16] = '{
        4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
    };

    localparam int R_Q1   = 13;
    localparam int R_Q2   = 12;
    localparam int R_Q3   = 18;
    localparam int R_OUT  = 8;
    localparam int R_BASE = R_Q1 + R_Q2 + R_Q3;

`ifdef PRINCE_SBOX_REMASK_OUT_EN
    localparam int LAT_SBOX = 5;
    localparam int R_W_DEF  = R_BASE + R_OUT;
`else
    localparam int LAT_SBOX = 4;
    localparam int R_W_DEF  = R_BASE;
`endif

    // Algebraic normal form of output bit b: bit u set means monomial prod(x[j], j in u) is present.
    function automatic logic [15:0] sbox_anf(input int b);
        logic [15:0] a;
        for (int x = 0; x < 16; x++) begin
            a[x] = SBOX[x][b];
        end
        for (int i = 0; i < 4; i++) begin
            for (int x = 0; x < 16; x++) begin
                if (((x >> i) & 1) == 1) begin
                    a[x] = a[x] ^ a[x ^ (1 << i)];
                end
            end
        end
        return a;
    endfunction

    // Share of the monomial vector: bit 0 is the constant term, bits 1/2/4/8 are x[0..3].
    function automatic logic [15:0] to_mono(input nibble_t x, input logic one);
        logic [15:0] m;
        m    = '0;
        m[0] = one;
        m[1] = x[0];
        m[2] = x[1];
        m[4] = x[2];
        m[8] = x[3];
        return m;
    endfunction

endpackage

// File: rtl/prince_q_stage_masked.sv
// One registered 3-share quadratic layer over the monomial vector: builds all monomials of
// degree DEG as masked products of a lower-degree pair, refreshes, and registers when en.
module prince_q_stage_masked
    import prince_mask_pkg::*;
#(
    parameter int DEG    = 2,
    parameter int R_BITS = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [15:0]       a1,
    input  logic [15:0]       a2,
    input  logic [15:0]       a3,
    input  logic [R_BITS-1:0] rnd,
    output logic [15:0]       m1,
    output logic [15:0]       m2,
    output logic [15:0]       m3
);

    logic [15:0] n1, n2, n3;
    logic        z12, z13, z23, t;
    int          k, lo, hi;

    always_comb begin
        n1  = a1;
        n2  = a2;
        n3  = a3;
        z12 = 1'b0;
        z13 = 1'b0;
        z23 = 1'b0;
        t   = 1'b0;
        k   = 0;
        lo  = 0;
        hi  = 0;
        for (int i = 1; i < 16; i++) begin
            if ($countones(i[3:0]) == DEG) begin
                lo  = i & (-i);
                hi  = i ^ lo;
                z12 = rnd[(3 * k) % R_BITS];
                z13 = rnd[(3 * k + 1) % R_BITS];
                z23 = rnd[(3 * k + 2) % R_BITS];
                // Each cross-domain mask enters exactly two share domains, so it cancels in the sum.
                n1[i] = (a1[lo] & a1[hi]) ^ ((a1[lo] & a2[hi]) ^ z12) ^ ((a1[lo] & a3[hi]) ^ z13);
                n2[i] = (a2[lo] & a2[hi]) ^ ((a2[lo] & a1[hi]) ^ z12) ^ ((a2[lo] & a3[hi]) ^ z23);
                n3[i] = (a3[lo] & a3[hi]) ^ ((a3[lo] & a1[hi]) ^ z13) ^ ((a3[lo] & a2[hi]) ^ z23);
                k = k + 1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            t     = rnd[(3 * k + i) % R_BITS];
            n1[i] = n1[i] ^ t;
            n3[i] = n3[i] ^ t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= '0;
            m2 <= '0;
            m3 <= '0;
        end else if (en) begin
            m1 <= n1;
            m2 <= n2;
            m3 <= n3;
        end
    end

endmodule

// File: rtl/prince_sbox_fwd_masked.sv
// 3-share masked forward PRINCE S-box, one nibble per cycle, 4-cycle latency.
// PRINCE_SBOX_REMASK_OUT_EN adds a refreshed output register (latency 5, R_W 51).
module prince_sbox_fwd_masked
    import prince_mask_pkg::*;
#(
    parameter int R_W    = R_W_DEF,
    parameter int SHARES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [3:0]     in1,
    input  logic [3:0]     in2,
    input  logic [3:0]     in3,
    input  logic [R_W-1:0] r,
    output logic           out_valid,
    output logic [3:0]     out1,
    output logic [3:0]     out2,
    output logic [3:0]     out3,
    output logic           busy
);

    localparam int LO_Q2 = R_Q1;
    localparam int LO_Q3 = R_Q1 + R_Q2;
    localparam int LO_RO = R_BASE;
    localparam logic [3:0][15:0] ANF = {sbox_anf(3), sbox_anf(2), sbox_anf(1), sbox_anf(0)};

    if (SHARES != 3) begin : g_shares_chk
        $error("prince_sbox_fwd_masked supports SHARES == 3 only");
    end

    logic [LAT_SBOX-1:0] vld;
    shares3_t            in_q;
    logic [R_W-1:0]      r_d0;
    logic [R_W-1:LO_Q2]  r_d1;
    logic [R_W-1:LO_Q3]  r_d2;
    logic [15:0]         q1_m1, q1_m2, q1_m3;
    logic [15:0]         q2_m1, q2_m2, q2_m3;
    logic [15:0]         q3_m1, q3_m2, q3_m3;
    nibble_t             c1, c2, c3;

    // Randomness travels with its nibble, so each stage consumes only its own slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            in_q <= '0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            vld <= {vld[LAT_SBOX-2:0], in_valid};
            if (in_valid) begin
                in_q <= {in3, in2, in1};
                r_d0 <= r;
            end
            if (vld[0]) r_d1 <= r_d0[R_W-1:LO_Q2];
            if (vld[1]) r_d2 <= r_d1[R_W-1:LO_Q3];
        end
    end

    prince_q_stage_masked #(.DEG(2), .R_BITS(R_Q1)) u_q1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (vld[0]),
        .a1    (to_mono(in_q.s1, 1'b1)),
        .a2    (to_mono(in_q.s2, 1'b0)),
        .a3    (to_mono(in_q.s3, 1'b0)),
        .rnd   (r_d0[LO_Q2-1:0]),
        .m1    (q1_m1),
        .m2    (q1_m2),
        .m3    (q1_m3)
    );

    prince_q_stage_masked #(.DEG(3), .R_BITS(R_Q2)) u_q2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (vld[1]),
        .a1    (q1_m1),
        .a2    (q1_m2),
        .a3    (q1_m3),
        .rnd   (r_d1[LO_Q3-1:LO_Q2]),
        .m1    (q2_m1),
        .m2    (q2_m2),
        .m3    (q2_m3)
    );

    prince_q_stage_masked #(.DEG(4), .R_BITS(R_Q3)) u_q3 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (vld[2]),
        .a1    (q2_m1),
        .a2    (q2_m2),
        .a3    (q2_m3),
        .rnd   (r_d2[LO_Q3+R_Q3-1:LO_Q3]),
        .m1    (q3_m1),
        .m2    (q3_m2),
        .m3    (q3_m3)
    );

    // Linear ANF map, applied within each share domain only.
    always_comb begin
        c1 = '0;
        c2 = '0;
        c3 = '0;
        for (int b = 0; b < 4; b++) begin
            c1[b] = ^(ANF[b] & q3_m1);
            c2[b] = ^(ANF[b] & q3_m2);
            c3[b] = ^(ANF[b] & q3_m3);
        end
    end

`ifdef PRINCE_SBOX_REMASK_OUT_EN
    logic [R_W-1:LO_RO] r_d3;
    nibble_t            o1, o2, o3;
    nibble_t            ra, rb;

    assign ra = r_d3[LO_RO+3:LO_RO];
    assign rb = r_d3[LO_RO+7:LO_RO+4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d3 <= '0;
            o1   <= '0;
            o2   <= '0;
            o3   <= '0;
        end else begin
            if (vld[2]) r_d3 <= r_d2[R_W-1:LO_RO];
            if (vld[3]) begin
                o1 <= c1 ^ ra;
                o2 <= c2 ^ rb;
                o3 <= c3 ^ ra ^ rb;
            end
        end
    end

    assign out1 = o1;
    assign out2 = o2;
    assign out3 = o3;
`else
    assign out1 = c1;
    assign out2 = c2;
    assign out3 = c3;
`endif

    assign out_valid = vld[LAT_SBOX-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_prince_sbox_fwd_masked.sv
// Self-checking bench for prince_sbox_fwd_masked (default and PRINCE_SBOX_REMASK_OUT_EN builds).
module tb_prince_sbox_fwd_masked;

`ifdef PRINCE_SBOX_REMASK_OUT_EN
    localparam int LAT = 5;
    localparam int RW  = 51;
`else
    localparam int LAT = 4;
    localparam int RW  = 43;
`endif

    localparam logic [3:0] S_TAB [16] = '{
        4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
    };
    localparam logic [3:0] S_INV [16] = '{
        4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    in1 = '0, in2 = '0, in3 = '0;
    logic [RW-1:0] r = '0;
    logic          out_valid, busy;
    logic [3:0]    out1, out2, out3;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    prince_sbox_fwd_masked #(.R_W(RW), .SHARES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .r         (r),
        .out_valid (out_valid),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: a nibble accepted at an edge emerges LAT edges later as S(x).
    logic       mv [1:LAT];
    logic [3:0] mx [1:LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= LAT; i++) begin
                mv[i] <= 1'b0;
                mx[i] <= '0;
            end
        end else begin
            mv[1] <= in_valid;
            mx[1] <= in1 ^ in2 ^ in3;
            for (int i = 2; i <= LAT; i++) begin
                mv[i] <= mv[i-1];
                mx[i] <= mx[i-1];
            end
        end
    end

    logic [11:0] prev_out;
    logic        have_prev = 1'b0;
    logic        busy_exp;
    logic [3:0]  y;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_shares", 32'({out1, out2, out3}), 32'(0));
            have_prev <= 1'b0;
        end else begin
            busy_exp = 1'b0;
            for (int i = 1; i <= LAT; i++) busy_exp = busy_exp | mv[i];
            y = out1 ^ out2 ^ out3;
            check("out_valid", 32'(out_valid), 32'(mv[LAT]));
            check("busy", 32'(busy), 32'(busy_exp));
            if (mv[LAT]) begin
                check("sbox", 32'(y), 32'(S_TAB[mx[LAT]]));
                check("inverse", 32'(S_INV[y]), 32'(mx[LAT]));
            end else if (have_prev) begin
                check("hold", 32'({out1, out2, out3}), 32'(prev_out));
            end
            prev_out  <= {out1, out2, out3};
            have_prev <= 1'b1;
        end
    end

    task automatic rand_r(output logic [RW-1:0] rr);
        logic [63:0] rv;
        rv = {$urandom, $urandom};
        rr = rv[RW-1:0];
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [RW-1:0] rr);
        @(negedge clk);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        in3 = c;
        r   = rr;
    endtask

    task automatic idle();
        logic [RW-1:0] rr;
        @(negedge clk);
        rand_r(rr);
        in_valid = 1'b0;
        in1 = 4'($urandom);
        in2 = 4'($urandom);
        in3 = 4'($urandom);
        r   = rr;
    endtask

    task automatic send_x(input logic [3:0] x);
        logic [3:0]    a, b;
        logic [RW-1:0] rr;
        a = 4'($urandom);
        b = 4'($urandom);
        rand_r(rr);
        send(a, b, x ^ a ^ b, rr);
    endtask

    initial begin
        logic [RW-1:0] rr;

        // Inputs during reset must be ignored.
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in1 = 4'h7;
            in2 = 4'h1;
            in3 = 4'h9;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) idle();

        // x = 0 with zero shares and zero randomness.
        send(4'h0, 4'h0, 4'h0, '0);
        idle();
        repeat (LAT - 1) @(negedge clk);
        check("lit_x0_valid", 32'(out_valid), 32'(1));
        check("lit_x0_value", 32'(out1 ^ out2 ^ out3), 32'hB);
        @(negedge clk);
        check("lit_x0_single", 32'(out_valid), 32'(0));

        // x = 4 from shares 3/5/2.
        rand_r(rr);
        send(4'h3, 4'h5, 4'h2, rr);
        idle();
        repeat (LAT - 1) @(negedge clk);
        check("lit_x4_valid", 32'(out_valid), 32'(1));
        check("lit_x4_value", 32'(out1 ^ out2 ^ out3), 32'hA);
        @(negedge clk);
        check("lit_x4_single", 32'(out_valid), 32'(0));

        // Back-to-back x = 0..F.
        for (int x = 0; x < 16; x++) send_x(4'(x));
        idle();
        repeat (LAT - 1) @(negedge clk);
        check("lit_xF_value", 32'(out1 ^ out2 ^ out3), 32'h4);
        check("lit_busy_last", 32'(busy), 32'(1));
        @(negedge clk);
        check("lit_busy_fall", 32'(busy), 32'(0));
        repeat (2) idle();

        // Alternating valid / bubble.
        for (int i = 0; i < 8; i++) begin
            send_x(4'(i * 3 + 1));
            idle();
        end
        repeat (LAT + 2) idle();

        // x = 7 with zero randomness but nonzero masks.
        send(4'hC, 4'h6, 4'hD, '0);
        idle();
        repeat (LAT - 1) @(negedge clk);
        check("lit_x7_value", 32'(out1 ^ out2 ^ out3), 32'h1);
        repeat (2) idle();

        // Asynchronous reset with three nibbles in flight.
        send_x(4'h5);
        send_x(4'hA);
        send_x(4'hE);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        check("async_shares", 32'({out1, out2, out3}), 32'(0));
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (LAT + 4) idle();

        // Random traffic with bubbles.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) != 0) send_x(4'($urandom));
            else idle();
        end
        repeat (LAT + 2) idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
